// File: rtl/dsi_packet_builder.sv
// dsi_packet_builder
// Turns a packet request plus a byte-wide payload stream into a serialized
// DSI packet (header + ECC, payload, CRC-16 footer) on a valid/ready byte
// stream that feeds the lane distribution stage.

module dsi_packet_builder #(
  parameter bit ECC_EN = 1'b1,
  parameter bit CRC_EN = 1'b1
) (
  input  logic        dsi_clk,
  input  logic        dsi_rst_n,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        pkt_long,
  input  logic [7:0]  pkt_di,
  input  logic [15:0] pkt_wc,
  input  logic [7:0]  pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        packet_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CRC,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic        long_q;
  logic [2:0]  hdr_cnt;
  logic [1:0]  crc_cnt;
  logic [15:0] remaining;
  logic [15:0] crc_q;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;

  logic        slot_free;
  logic        last_hs;
  logic        load_en;
  logic [7:0]  load_data;
  logic        load_last;
  logic [7:0]  ecc_byte;
  logic [15:0] crc_out;

  // Header ECC over the 24 header bits, D0 = DI bit 0.
  function automatic logic [7:0] calc_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return {2'b00, p};
  endfunction

  // Reflected CCITT CRC-16 (poly 0x8408), one byte, LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  assign ecc_byte  = ECC_EN ? calc_ecc({wc_q, di_q}) : 8'h00;
  assign crc_out   = CRC_EN ? crc_q : 16'h0000;
  assign slot_free = !out_valid || byte_ready;
  assign last_hs   = out_valid && out_last && byte_ready;

  assign byte_data  = out_data;
  assign byte_valid = out_valid;
  assign byte_last  = out_last;

  // State register.
  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the final byte handshake always leads to DONE.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (pkt_valid) next_state = S_HDR;
      end
      S_HDR: begin
        if (last_hs) begin
          next_state = S_DONE;
        end else if (slot_free && hdr_cnt == 3'd3 && long_q) begin
          next_state = (wc_q == 16'd0) ? S_CRC : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (pld_valid && slot_free && remaining == 16'd1) next_state = S_CRC;
      end
      S_CRC: begin
        if (last_hs) next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Handshake outputs and selection of the next byte for the output register.
  always_comb begin
    pkt_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    packet_done = (state == S_DONE);
    pld_ready   = 1'b0;
    load_en     = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pkt_valid) begin
          load_en   = 1'b1;
          load_data = pkt_di;
        end
      end
      S_HDR: begin
        if (slot_free && hdr_cnt != 3'd4) begin
          load_en = 1'b1;
          case (hdr_cnt)
            3'd1:    load_data = wc_q[7:0];
            3'd2:    load_data = wc_q[15:8];
            default: begin
              load_data = ecc_byte;
              load_last = !long_q;
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        pld_ready = slot_free && (remaining != 16'd0);
        if (pld_valid && slot_free && (remaining != 16'd0)) begin
          load_en   = 1'b1;
          load_data = pld_data;
        end
      end
      S_CRC: begin
        if (slot_free && crc_cnt != 2'd2) begin
          load_en   = 1'b1;
          load_data = (crc_cnt == 2'd0) ? crc_out[7:0] : crc_out[15:8];
          load_last = (crc_cnt == 2'd1);
        end
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  // Single-entry output register; holds its byte until the downstream takes it.
  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (slot_free) begin
      out_valid <= load_en;
      out_last  <= load_en && load_last;
      if (load_en) out_data <= load_data;
    end
  end

  // Request fields are captured once at accept and stay put for the whole packet.
  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      di_q   <= 8'h00;
      wc_q   <= 16'h0000;
      long_q <= 1'b0;
    end else if (state == S_IDLE && pkt_valid) begin
      di_q   <= pkt_di;
      wc_q   <= pkt_wc;
      long_q <= pkt_long;
    end
  end

  // Header/footer byte counters, payload countdown and running CRC.
  always_ff @(posedge dsi_clk) begin
    if (!dsi_rst_n) begin
      hdr_cnt   <= 3'd0;
      crc_cnt   <= 2'd0;
      remaining <= 16'd0;
      crc_q     <= 16'hFFFF;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_valid) begin
            hdr_cnt   <= 3'd1;
            crc_cnt   <= 2'd0;
            remaining <= pkt_wc;
            crc_q     <= 16'hFFFF;
          end
        end
        S_HDR: begin
          if (load_en) hdr_cnt <= hdr_cnt + 3'd1;
        end
        S_PAYLOAD: begin
          if (load_en) begin
            remaining <= remaining - 16'd1;
            crc_q     <= crc_step(crc_q, pld_data);
          end
        end
        S_CRC: begin
          if (load_en) crc_cnt <= crc_cnt + 2'd1;
        end
        default: begin
          hdr_cnt <= hdr_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_builder.sv
// tb_dsi_packet_builder
// Scoreboard bench: stimulus pushes expected bytes into queues, monitors pop
// and compare on every byte handshake. A second instance with ECC and CRC
// disabled runs on the same stimulus.

module tb_dsi_packet_builder;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] kind;
  } exp_t;

  logic        dsi_clk = 1'b0;
  logic        dsi_rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_long = 1'b0;
  logic [7:0]  pkt_di = 8'h00;
  logic [15:0] pkt_wc = 16'h0000;
  logic [7:0]  pld_data = 8'h00;
  logic        pld_valid = 1'b0;
  logic        byte_ready = 1'b1;

  logic        pkt_ready, pld_ready, byte_valid, byte_last, packet_done, busy;
  logic [7:0]  byte_data;
  logic        pkt_ready_p, pld_ready_p, byte_valid_p, byte_last_p, packet_done_p, busy_p;
  logic [7:0]  byte_data_p;

  exp_t        exp_q[$];
  exp_t        exp_p_q[$];
  logic [7:0]  pld_bytes[$];

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_pat = 16'b1010_0111_0010_1101;

  dsi_packet_builder dut (
    .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_long(pkt_long),
    .pkt_di(pkt_di), .pkt_wc(pkt_wc),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .packet_done(packet_done), .busy(busy)
  );

  dsi_packet_builder #(.ECC_EN(1'b0), .CRC_EN(1'b0)) dut_plain (
    .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready_p), .pkt_long(pkt_long),
    .pkt_di(pkt_di), .pkt_wc(pkt_wc),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready_p),
    .byte_data(byte_data_p), .byte_valid(byte_valid_p), .byte_ready(byte_ready),
    .byte_last(byte_last_p), .packet_done(packet_done_p), .busy(busy_p)
  );

  always #5 dsi_clk = ~dsi_clk;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Reference CRC in shift-register form, one bit at a time, LSB first.
  function automatic logic [15:0] crcModel();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pld_bytes[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pld_bytes[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic void pushExp(input logic [7:0] d, input logic l, input logic [1:0] k);
    exp_t e;
    e.data = d; e.last = l; e.kind = k;
    exp_q.push_back(e);
    if (k != 2'd0) e.data = 8'h00;
    exp_p_q.push_back(e);
  endfunction

  // Downstream backpressure pattern, driven just after each rising edge.
  initial begin
    forever begin
      @(posedge dsi_clk);
      #1;
      cyc++;
      byte_ready = bp_en ? bp_pat[cyc % 16] : 1'b1;
    end
  end

  // Monitor for the main instance: byte order, hold stability, done pulse.
  initial begin
    exp_t       e;
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;
    logic       held_last = 1'b0;
    int         done_wait = 0;
    forever begin
      @(negedge dsi_clk);
      if (!dsi_rst_n) begin
        held = 1'b0;
        done_wait = 0;
      end else begin
        if (done_wait == 1) begin
          checkOutput("packet_done pulse", {31'd0, packet_done}, 32'd1);
          checkOutput("busy during done", {31'd0, busy}, 32'd1);
          done_wait = 2;
        end else if (done_wait == 2) begin
          checkOutput("packet_done width", {31'd0, packet_done}, 32'd0);
          done_wait = 0;
        end else if (packet_done) begin
          checkOutput("spurious packet_done", {31'd0, packet_done}, 32'd0);
        end
        if (held) begin
          checkOutput("hold valid", {31'd0, byte_valid}, 32'd1);
          checkOutput("hold data", {24'd0, byte_data}, {24'd0, held_data});
          checkOutput("hold last", {31'd0, byte_last}, {31'd0, held_last});
        end
        if (byte_valid && byte_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected byte: got 0x%0h, expected no byte", byte_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("byte data", {24'd0, byte_data}, {24'd0, e.data});
            checkOutput("byte last", {31'd0, byte_last}, {31'd0, e.last});
            if (e.last) done_wait = 1;
          end
        end else if (byte_valid) begin
          held = 1'b1;
          held_data = byte_data;
          held_last = byte_last;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // Monitor for the instance with ECC and CRC disabled.
  initial begin
    exp_t e;
    forever begin
      @(negedge dsi_clk);
      if (dsi_rst_n && byte_valid_p && byte_ready) begin
        if (exp_p_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL plain unexpected byte: got 0x%0h, expected no byte", byte_data_p);
        end else begin
          e = exp_p_q.pop_front();
          checkOutput("plain byte data", {24'd0, byte_data_p}, {24'd0, e.data});
          checkOutput("plain byte last", {31'd0, byte_last_p}, {31'd0, e.last});
        end
      end
    end
  end

  task automatic tick();
    @(posedge dsi_clk);
    #1;
  endtask

  // Queue the expected bytes and hand the request over.
  task automatic requestPacket(input logic lng, input logic [7:0] di, input logic [15:0] wc,
                               input logic [7:0] ecc, input logic [15:0] crc);
    logic rdy;
    pushExp(di, 1'b0, 2'd0);
    pushExp(wc[7:0], 1'b0, 2'd0);
    pushExp(wc[15:8], 1'b0, 2'd0);
    pushExp(ecc, !lng, 2'd1);
    if (lng) begin
      foreach (pld_bytes[i]) pushExp(pld_bytes[i], 1'b0, 2'd0);
      pushExp(crc[7:0], 1'b0, 2'd2);
      pushExp(crc[15:8], 1'b1, 2'd2);
    end
    pkt_valid = 1'b1;
    pkt_long  = lng;
    pkt_di    = di;
    pkt_wc    = wc;
    rdy = 1'b0;
    for (int t = 0; t < 50 && !rdy; t++) begin
      @(negedge dsi_clk);
      rdy = pkt_ready;
      tick();
    end
    pkt_valid = 1'b0;
    if (!rdy) checkOutput("request accept timeout", {31'd0, rdy}, 32'd1);
    else checkOutput("first byte latency", {31'd0, byte_valid}, 32'd1);
  endtask

  // Offer the first n payload bytes, with optional idle gaps.
  task automatic feedPayload(input int n, input logic gaps);
    logic got;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        pld_valid = 1'b0;
        tick();
        tick();
      end
      pld_valid = 1'b1;
      pld_data  = pld_bytes[i];
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge dsi_clk);
        got = pld_ready;
        tick();
      end
      if (!got) checkOutput("payload accept timeout", {31'd0, got}, 32'd1);
    end
    pld_valid = 1'b0;
  endtask

  // Offer surplus bytes that must be refused, then wait for the packet to drain.
  task automatic finishPacket(input logic surplus);
    logic idle;
    if (surplus) begin
      pld_valid = 1'b1;
      pld_data  = 8'hEE;
      for (int t = 0; t < 3; t++) begin
        @(negedge dsi_clk);
        checkOutput("pld_ready after last payload", {31'd0, pld_ready}, 32'd0);
        tick();
      end
      pld_valid = 1'b0;
    end
    idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(negedge dsi_clk);
      idle = !busy;
    end
    checkOutput("packet drains", {31'd0, idle}, 32'd1);
    checkOutput("bytes outstanding", exp_q.size(), 32'd0);
    checkOutput("plain bytes outstanding", exp_p_q.size(), 32'd0);
    tick();
  endtask

  task automatic applyStimulus(input logic lng, input logic [7:0] di, input logic [15:0] wc,
                               input logic [7:0] ecc, input logic [15:0] crc, input logic gaps);
    requestPacket(lng, di, wc, ecc, crc);
    if (lng && wc != 16'd0) feedPayload(pld_bytes.size(), gaps);
    finishPacket(lng && wc != 16'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dsi_rst_n = 1'b0;
    tick();
    tick();
    checkOutput("reset pkt_ready", {31'd0, pkt_ready}, 32'd1);
    checkOutput("reset pld_ready", {31'd0, pld_ready}, 32'd0);
    checkOutput("reset byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("reset byte_last", {31'd0, byte_last}, 32'd0);
    checkOutput("reset packet_done", {31'd0, packet_done}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset byte_data", {24'd0, byte_data}, 32'd0);
    dsi_rst_n = 1'b1;
    tick();

    $display("[TB] short packet di=0x01");
    pld_bytes.delete();
    applyStimulus(1'b0, 8'h01, 16'h0000, 8'h07, 16'h0000, 1'b0);
    checkOutput("idle busy", {31'd0, busy}, 32'd0);
    checkOutput("idle pkt_ready", {31'd0, pkt_ready}, 32'd1);

    $display("[TB] short packet all zero");
    applyStimulus(1'b0, 8'h00, 16'h0000, 8'h00, 16'h0000, 1'b0);

    $display("[TB] long packet wc=0");
    applyStimulus(1'b1, 8'h39, 16'h0000, 8'h0F, 16'hFFFF, 1'b0);

    $display("[TB] long packet wc=6 with backpressure and gaps");
    bp_en = 1'b1;
    pld_bytes = '{8'h10, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA5};
    applyStimulus(1'b1, 8'h29, 16'h0006, 8'h23, crcModel(), 1'b1);

    $display("[TB] short packet with data under backpressure");
    pld_bytes.delete();
    applyStimulus(1'b0, 8'h15, 16'h1234, 8'h18, 16'h0000, 1'b0);

    $display("[TB] long packet 123456789");
    pld_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    applyStimulus(1'b1, 8'h29, 16'h0009, 8'h23, 16'h6F91, 1'b1);

    $display("[TB] reset during payload");
    bp_en = 1'b0;
    pld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    requestPacket(1'b1, 8'h29, 16'h0009, 8'h23, 16'h0000);
    feedPayload(3, 1'b0);
    dsi_rst_n = 1'b0;
    tick();
    checkOutput("abort byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort pkt_ready", {31'd0, pkt_ready}, 32'd1);
    exp_q.delete();
    exp_p_q.delete();
    dsi_rst_n = 1'b1;
    tick();
    pld_bytes.delete();
    applyStimulus(1'b0, 8'h01, 16'h0000, 8'h07, 16'h0000, 1'b0);
    applyStimulus(1'b1, 8'h39, 16'h0000, 8'h0F, 16'hFFFF, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dsi_packet_builder.md
Name: dsi_packet_builder

Overview:
- Upstream neighbour of the lane distribution stage.
- Takes a packet request (data identifier, word count or short-packet data, long/short flag) plus a byte-wide payload stream.
- Emits the complete serialized DSI packet as a byte stream with valid/ready flow control: header with ECC, payload, and CRC-16 footer.
- The lane distribution stage consumes this stream and stripes it across the PPI lanes.

Parameters:
ECC_EN  1  1: compute header ECC; 0: ECC byte driven 0x00
CRC_EN  1  1: compute payload CRC-16; 0: footer driven 0x0000

Ports:
dsi_clk  input  1  block clock, all logic on rising edge
dsi_rst_n  input  1  synchronous active-low reset
pkt_valid  input  1  packet request valid
pkt_ready  output  1  builder idle, request accepted when pkt_valid&pkt_ready
pkt_long  input  1  1 = long packet, 0 = short packet
pkt_di  input  8  data identifier {VC[1:0],DT[5:0]}
pkt_wc  input  16  long: word count in bytes; short: {data1,data0}
pld_data  input  8  payload byte
pld_valid  input  1  payload byte valid
pld_ready  output  1  payload byte accepted when pld_valid&pld_ready
byte_data  output  8  serialized packet byte
byte_valid  output  1  byte_data valid
byte_ready  input  1  downstream accepts byte
byte_last  output  1  marks final byte of packet, qualified by byte_valid
packet_done  output  1  one-cycle pulse after the last byte handshake
busy  output  1  high from request accept through packet_done

Behaviour:
- Reset (dsi_rst_n=0 at a rising edge) forces:
  - state IDLE; pkt_ready=1; pld_ready=0; byte_valid=0; byte_last=0; packet_done=0; busy=0; byte_data=0x00; CRC register 0xFFFF.
- Reset mid-packet aborts immediately; no partial footer is emitted.
- States: IDLE -> HDR -> (PAYLOAD) -> (CRC) -> DONE -> IDLE.
- IDLE:
  - pkt_ready=1.
  - On accept, latch di/wc/long, compute ECC combinationally from the latched {wc[15:8],wc[7:0],di}, and go to HDR.
  - First byte_valid is asserted the cycle after accept.
- Output stage is a single register: a new byte loads when !byte_valid or byte_ready. byte_data/byte_last are held stable while byte_valid&!byte_ready.
- HDR emits 4 bytes in order: DI, wc[7:0], wc[15:8], ECC.
  - Short packet: after ECC, byte_last=1 on the ECC byte -> DONE.
  - Long packet, wc>0 -> PAYLOAD; long packet, wc=0 -> CRC.
- PAYLOAD:
  - pld_ready = state==PAYLOAD & output slot free & remaining>0.
  - Each accepted pld byte goes to the output register and updates the CRC.
  - The 16-bit remaining counter decrements per accept; on reaching 0 -> CRC.
  - pld_valid low stalls with byte_valid low (a bubble); no data invented.
- CRC state emits crc[7:0] then crc[15:8], with byte_last=1 on the second byte. After the last handshake -> DONE.
- DONE: packet_done=1 for exactly one cycle, busy drops, then IDLE. A new request may be accepted in the IDLE cycle after DONE.
- ECC, data bits D0..D23 = {byte2,byte1,byte0} LSB = DI bit0:
  - P0 = ^{D0,D1,D2,D4,D5,D7,D10,D11,D13,D16,D20,D21,D22,D23}
  - P1 = ^{D0,D1,D3,D4,D6,D8,D10,D12,D14,D17,D20,D21,D22,D23}
  - P2 = ^{D0,D2,D3,D5,D6,D9,D11,D12,D15,D18,D20,D21,D22}
  - P3 = ^{D1,D2,D3,D7,D8,D9,D13,D14,D15,D19,D20,D21,D23}
  - P4 = ^{D4..D9,D16..D20,D22,D23}
  - P5 = ^{D10..D19,D21,D22,D23}
  - ECC = {2'b00,P5..P0}.
- CRC:
  - x^16+x^12+x^5+1, bit-reflected, LSB of each byte first.
  - Init 0xFFFF at each packet accept, no final XOR.
  - CRC is 0xFFFF for wc=0.
- pkt_valid while busy is ignored (pkt_ready=0). Surplus pld bytes are never consumed.

Test Plan:
- Reset: hold dsi_rst_n=0 two cycles -> all outputs at reset values, pkt_ready=1.
- Short packet: di=0x01, wc=0x0000, byte_ready=1 -> bytes 0x01,0x00,0x00,0x07.
  - byte_last on 4th byte; packet_done one cycle after; first byte one cycle after accept.
- Short packet, all-zero header -> bytes 0x00,0x00,0x00,0x00.
  - With ECC_EN=0, di=0x01 -> ECC byte 0x00.
- Long packet: di=0x39, wc=0 -> 6 bytes: 0x39,0x00,0x00,ECC,0xFF,0xFF, byte_last on the final 0xFF.
- Long packet, wc=6 with random byte_ready and pld_valid gaps:
  - Exactly 12 bytes out; payload bytes in order; CRC matches the reference model; byte_data stable under backpressure.
  - pld_ready deasserts after the 6th payload byte.
- Reset asserted during PAYLOAD:
  - Next cycle byte_valid=0, busy=0.
  - A following short packet is emitted correctly with CRC re-initialised.
